// File: rtl/icnbc_sweep_ctrl_if.sv
// Signal bundle between the sweep controller and its surroundings:
// the host config port, one ICNBC search engine and the result sink.
// The controller uses the master view; the host/engine/sink side uses slave.
interface icnbc_sweep_ctrl_if #(
    parameter int NW    = 4,
    parameter int CNT_W = 10
);
    // Host sweep request
    logic            cfg_valid;
    logic            cfg_ready;
    logic [NW-1:0]   cfg_n_lo;
    logic [NW-1:0]   cfg_n_hi;
    logic [NW-1:0]   cfg_ld_lo;
    logic [NW-1:0]   cfg_ld_hi;
    logic            cfg_err;
    logic            abort;

    // Search engine control
    logic            eng_start;
    logic            eng_abort;
    logic [NW-1:0]   eng_n;
    logic [NW-1:0]   eng_min_ld;
    logic            eng_done;
    logic [CNT_W-1:0] eng_count;

    // Result stream
    logic            res_valid;
    logic            res_ready;
    logic [NW-1:0]   res_n;
    logic [NW-1:0]   res_ld;
    logic [CNT_W-1:0] res_count;
    logic            res_timeout;

    // Status
    logic            busy;
    logic            sweep_done;

    modport master (
        input  cfg_valid, cfg_n_lo, cfg_n_hi, cfg_ld_lo, cfg_ld_hi, abort,
        input  eng_done, eng_count, res_ready,
        output cfg_ready, cfg_err, eng_start, eng_abort, eng_n, eng_min_ld,
        output res_valid, res_n, res_ld, res_count, res_timeout, busy, sweep_done
    );

    modport slave (
        output cfg_valid, cfg_n_lo, cfg_n_hi, cfg_ld_lo, cfg_ld_hi, abort,
        output eng_done, eng_count, res_ready,
        input  cfg_ready, cfg_err, eng_start, eng_abort, eng_n, eng_min_ld,
        input  res_valid, res_n, res_ld, res_count, res_timeout, busy, sweep_done
    );
endinterface

// File: rtl/icnbc_sweep_ctrl.sv
// ICNBC sweep scheduler.
// Walks a rectangular (n, min_ld) grid, ld inner loop and n outer loop,
// launching one engine run per pair and streaming out each codebook size.
// Pairs with min_ld > n need no run: their codebook is the single word, count 1.
module icnbc_sweep_ctrl #(
    parameter int N_MAX   = 8,
    parameter int NW      = 4,
    parameter int CNT_W   = 10,
    parameter int TIMEOUT = 65535
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    icnbc_sweep_ctrl_if.master   bus
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_EMIT,
        ST_NEXT,
        ST_FINISH
    } state_t;

    state_t            state_q;

    logic [NW-1:0]     n_hi_q;
    logic [NW-1:0]     ld_lo_q;
    logic [NW-1:0]     ld_hi_q;
    logic [NW-1:0]     cur_n_q;
    logic [NW-1:0]     cur_ld_q;
    logic [TW-1:0]     wait_cnt_q;

    logic              cfg_err_q;
    logic              eng_start_q;
    logic              eng_abort_q;
    logic              sweep_done_q;
    logic              res_valid_q;
    logic [NW-1:0]     res_n_q;
    logic [NW-1:0]     res_ld_q;
    logic [CNT_W-1:0]  res_count_q;
    logic              res_timeout_q;

    logic              cfg_ok_d;
    logic              last_pair_d;
    logic [NW-1:0]     cur_n_d;
    logic [NW-1:0]     cur_ld_d;
    logic [TW-1:0]     wait_cnt_d;
    logic              timeout_hit_d;

    // Request legality, next grid position and wait-counter expiry
    always_comb begin
        cfg_ok_d = (bus.cfg_n_lo != '0)
                && (bus.cfg_ld_lo != '0)
                && (bus.cfg_n_lo <= bus.cfg_n_hi)
                && (bus.cfg_n_hi <= NW'(N_MAX))
                && (bus.cfg_ld_lo <= bus.cfg_ld_hi);

        last_pair_d = (cur_n_q == n_hi_q) && (cur_ld_q == ld_hi_q);

        cur_n_d  = cur_n_q;
        cur_ld_d = cur_ld_q + NW'(1);
        if (cur_ld_q >= ld_hi_q) begin
            cur_n_d  = cur_n_q + NW'(1);
            cur_ld_d = ld_lo_q;
        end

        wait_cnt_d    = wait_cnt_q + TW'(1);
        timeout_hit_d = (wait_cnt_d == TW'(TIMEOUT));
    end

    // Sweep sequencer; every pulse and result field is a register so the
    // engine and the result sink see glitch-free outputs. eng_start is
    // raised on the edge that enters LAUNCH, so it is high during LAUNCH.
    // Reset does not pulse eng_abort because the engine is reset alongside.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            n_hi_q        <= '0;
            ld_lo_q       <= '0;
            ld_hi_q       <= '0;
            cur_n_q       <= '0;
            cur_ld_q      <= '0;
            wait_cnt_q    <= '0;
            cfg_err_q     <= 1'b0;
            eng_start_q   <= 1'b0;
            eng_abort_q   <= 1'b0;
            sweep_done_q  <= 1'b0;
            res_valid_q   <= 1'b0;
            res_n_q       <= '0;
            res_ld_q      <= '0;
            res_count_q   <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            cfg_err_q    <= 1'b0;
            eng_start_q  <= 1'b0;
            eng_abort_q  <= 1'b0;
            sweep_done_q <= 1'b0;

            if (bus.abort && (state_q != ST_IDLE) && (state_q != ST_FINISH)) begin
                eng_abort_q  <= (state_q == ST_WAIT);
                res_valid_q  <= 1'b0;
                sweep_done_q <= 1'b1;
                state_q      <= ST_FINISH;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.cfg_valid) begin
                            if (cfg_ok_d) begin
                                n_hi_q      <= bus.cfg_n_hi;
                                ld_lo_q     <= bus.cfg_ld_lo;
                                ld_hi_q     <= bus.cfg_ld_hi;
                                cur_n_q     <= bus.cfg_n_lo;
                                cur_ld_q    <= bus.cfg_ld_lo;
                                eng_start_q <= (bus.cfg_ld_lo <= bus.cfg_n_lo);
                                state_q     <= ST_LAUNCH;
                            end else begin
                                cfg_err_q   <= 1'b1;
                            end
                        end
                    end

                    ST_LAUNCH: begin
                        if (cur_ld_q > cur_n_q) begin
                            res_n_q       <= cur_n_q;
                            res_ld_q      <= cur_ld_q;
                            res_count_q   <= CNT_W'(1);
                            res_timeout_q <= 1'b0;
                            res_valid_q   <= 1'b1;
                            state_q       <= ST_EMIT;
                        end else begin
                            wait_cnt_q    <= '0;
                            state_q       <= ST_WAIT;
                        end
                    end

                    ST_WAIT: begin
                        if (bus.eng_done) begin
                            res_n_q       <= cur_n_q;
                            res_ld_q      <= cur_ld_q;
                            res_count_q   <= bus.eng_count;
                            res_timeout_q <= 1'b0;
                            res_valid_q   <= 1'b1;
                            state_q       <= ST_EMIT;
                        end else if (timeout_hit_d) begin
                            eng_abort_q   <= 1'b1;
                            res_n_q       <= cur_n_q;
                            res_ld_q      <= cur_ld_q;
                            res_count_q   <= '0;
                            res_timeout_q <= 1'b1;
                            res_valid_q   <= 1'b1;
                            state_q       <= ST_EMIT;
                        end else begin
                            wait_cnt_q    <= wait_cnt_d;
                        end
                    end

                    ST_EMIT: begin
                        if (bus.res_ready) begin
                            res_valid_q <= 1'b0;
                            state_q     <= ST_NEXT;
                        end
                    end

                    ST_NEXT: begin
                        if (last_pair_d) begin
                            sweep_done_q <= 1'b1;
                            state_q      <= ST_FINISH;
                        end else begin
                            cur_n_q     <= cur_n_d;
                            cur_ld_q    <= cur_ld_d;
                            eng_start_q <= (cur_ld_d <= cur_n_d);
                            state_q     <= ST_LAUNCH;
                        end
                    end

                    ST_FINISH: begin
                        state_q <= ST_IDLE;
                    end

                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.cfg_ready   = (state_q == ST_IDLE);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.cfg_err     = cfg_err_q;
    assign bus.eng_start   = eng_start_q;
    assign bus.eng_abort   = eng_abort_q;
    assign bus.eng_n       = cur_n_q;
    assign bus.eng_min_ld  = cur_ld_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_n       = res_n_q;
    assign bus.res_ld      = res_ld_q;
    assign bus.res_count   = res_count_q;
    assign bus.res_timeout = res_timeout_q;
    assign bus.sweep_done  = sweep_done_q;

endmodule
